// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and constants for the MEM-stage access controller
package mem_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE, ABORT} state_t;
    localparam int          TIMEOUT_DEFAULT = 16;
    localparam logic [15:0] ACCESS_CNT_MAX  = 16'hFFFF;
endpackage

// File: rtl/ack_timeout_counter.sv
// ack_timeout_counter: counts cycles spent waiting for a memory ack and flags the timeout cycle
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the counter
//   en         : advance the counter by one
//   count      : current wait count
//   expired    : count has reached TIMEOUT_CYCLES-1
module ack_timeout_counter
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expired
);
    always_ff @(posedge clk) begin
        if (reset || clear) count <= '0;
        else if (en)        count <= count + 1'b1;
    end
    assign expired = count == CNT_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage data-memory accesses and drives MEM/WB enable/bubble
//   clk, reset                  : clock, synchronous active-high reset
//   validM/memReadM/memWriteM   : M-stage instruction qualifiers
//   flushM                      : squash the instruction in M
//   memAck                      : memory completes the current request
//   memReq, memWe               : registered memory request and write strobe
//   stallM, wbEn, bubbleW       : combinational pipeline controls
//   timeoutErr                  : sticky timeout flag
//   accessCount                 : saturating count of completed accesses
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validM,
    input  logic        memReadM,
    input  logic        memWriteM,
    input  logic        flushM,
    input  logic        memAck,
    output logic        memReq,
    output logic        memWe,
    output logic        stallM,
    output logic        wbEn,
    output logic        bubbleW,
    output logic        timeoutErr,
    output logic [15:0] accessCount
);
    state_t           state, next_state;
    logic             squash, mem_op, cnt_clear, cnt_en, expired;
    logic [CNT_W-1:0] wait_cnt;

    assign mem_op = validM & ~flushM & (memReadM | memWriteM);

    ack_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .en     (cnt_en),
        .count  (wait_cnt),
        .expired(expired)
    );

    always_comb begin
        next_state = state;
        stallM     = 1'b0;
        wbEn       = 1'b1;
        bubbleW    = 1'b0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                stallM     = mem_op;
                wbEn       = ~mem_op;
                bubbleW    = ~(validM & ~flushM);
                cnt_clear  = 1'b1;
                next_state = mem_op ? ACCESS : IDLE;
            end
            ACCESS: begin
                stallM     = 1'b1;
                wbEn       = 1'b0;
                cnt_en     = ~memAck;
                // an ack on the timeout cycle still completes the access
                next_state = memAck ? COMPLETE : expired ? ABORT : ACCESS;
            end
            COMPLETE: begin
                bubbleW    = squash;
                next_state = IDLE;
            end
            ABORT: begin
                bubbleW    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            squash      <= 1'b0;
            timeoutErr  <= 1'b0;
            accessCount <= '0;
        end else begin
            state      <= next_state;
            memReq     <= next_state == ACCESS;
            // write strobe is captured on entry and held for the whole access
            memWe      <= (next_state == ACCESS) & ((state == IDLE) ? memWriteM : memWe);
            // a flush during ACCESS cannot cancel a possibly committed store, so remember it
            squash     <= (state == ACCESS) & (squash | flushM);
            timeoutErr <= timeoutErr | (state == ABORT);
            if (state == COMPLETE && accessCount != ACCESS_CNT_MAX)
                accessCount <= accessCount + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS)
            assert (wait_cnt < CNT_W'(TIMEOUT_CYCLES));
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized transaction-level check of mem_access_ctrl
module tb_mem_access_ctrl;
    localparam int T = 16;
    logic        clk = 1'b0;
    logic        reset, validM, memReadM, memWriteM, flushM, memAck;
    logic        memReq, memWe, stallM, wbEn, bubbleW, timeoutErr;
    logic [15:0] accessCount;
    int          checks = 0, errors = 0;
    logic [15:0] exp_count;
    logic        exp_err;

    mem_access_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .validM     (validM),
        .memReadM   (memReadM),
        .memWriteM  (memWriteM),
        .flushM     (flushM),
        .memAck     (memAck),
        .memReq     (memReq),
        .memWe      (memWe),
        .stallM     (stallM),
        .wbEn       (wbEn),
        .bubbleW    (bubbleW),
        .timeoutErr (timeoutErr),
        .accessCount(accessCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic s, input logic w, input logic b,
                        input logic b_chk, input logic r, input logic we);
        @(negedge clk);
        chk({tag, ".stallM"}, 32'(stallM), 32'(s));
        chk({tag, ".wbEn"}, 32'(wbEn), 32'(w));
        if (b_chk) chk({tag, ".bubbleW"}, 32'(bubbleW), 32'(b));
        chk({tag, ".memReq"}, 32'(memReq), 32'(r));
        chk({tag, ".memWe"}, 32'(memWe), 32'(we));
        chk({tag, ".timeoutErr"}, 32'(timeoutErr), 32'(exp_err));
        chk({tag, ".accessCount"}, 32'(accessCount), 32'(exp_count));
        @(posedge clk);
        #1;
    endtask

    // kind: 0 bubble, 1 flushed, 2 alu, 3 load, 4 store, 5 load+store
    // lat: ack arrives on this ACCESS cycle; beyond T means it never arrives
    task automatic run_op(input int kind, input int lat, input int flush_at);
        logic st, sq;
        int   n;
        validM    = (kind != 0);
        flushM    = (kind == 1);
        memReadM  = (kind == 3 || kind == 5) || (kind < 2 && $urandom_range(0, 1) == 1);
        memWriteM = (kind >= 4) || (kind < 2 && $urandom_range(0, 1) == 1);
        memAck    = ($urandom_range(0, 1) == 1);
        st        = (kind >= 4);
        if (kind < 3) begin
            look("nomem", 1'b0, 1'b1, kind < 2, 1'b1, 1'b0, 1'b0);
            return;
        end
        look("detect", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sq = 1'b0;
        n  = (lat > T) ? T : lat;
        for (int i = 1; i <= n; i++) begin
            memAck = (i == lat);
            flushM = (i == flush_at);
            look("access", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, st);
            sq = sq | flushM;
        end
        memAck = ($urandom_range(0, 1) == 1);
        flushM = ($urandom_range(0, 1) == 1);
        if (lat <= T) begin
            look("complete", 1'b0, 1'b1, sq, 1'b1, 1'b0, 1'b0);
            if (exp_count != 16'hFFFF) exp_count++;
        end else begin
            look("abort", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            exp_err = 1'b1;
        end
    endtask

    initial begin
        int kind, lat, fa;
        reset = 1'b1; validM = 1'b0; memReadM = 1'b0; memWriteM = 1'b0; flushM = 1'b0; memAck = 1'b0;
        exp_count = '0;
        exp_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        look("reset", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) run_op(2, 1, 0);
        run_op(3, 3, 0);
        run_op(5, 1, 0);
        run_op(3, 2, 1);
        run_op(3, 99, 0);
        repeat (4) begin
            run_op(0, 1, 0);
            memAck = 1'b1;
            look("idle_ack", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        run_op(4, 4, 0);
        for (int k = 0; k < 150; k++) begin
            kind = $urandom_range(0, 5);
            lat  = $urandom_range(1, 20);
            fa   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, lat) : 0;
            run_op(kind, lat, fa);
        end
        validM = 1'b1; memReadM = 1'b1; memWriteM = 1'b0; flushM = 1'b0; memAck = 1'b0;
        look("rst_detect", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        look("rst_access", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; validM = 1'b0; memAck = 1'b1;
        exp_count = '0;
        exp_err   = 1'b0;
        look("post_reset", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        look("post_reset2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(3, 1, 0);
        force dut.accessCount = 16'hFFFE;
        #1;
        release dut.accessCount;
        exp_count = 16'hFFFE;
        run_op(3, 2, 0);
        run_op(5, 1, 0);
        run_op(2, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
